// File: rtl/calc_pkg.sv
// calc_pkg: shared types and helpers for the calc_seq BCD calculator.
//   op_t           pending arithmetic operation
//   state_t        sequencer state
//   DigitW         bits per BCD digit
//   bcd_digit_add  one-digit BCD add/subtract with decimal correction
//   key_encode     one-hot keypad to digit, lowest index wins
package calc_pkg;

   localparam int unsigned DigitW = 4;

   typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB} op_t;

   typedef enum logic [2:0] {S_IDLE, S_ADD, S_SUB, S_CPL, S_DONE} state_t;

   // Returns {carry/borrow out, digit}. Operands must be valid BCD digits.
   function automatic logic [DigitW:0] bcd_digit_add(input logic [DigitW-1:0] a,
                                                     input logic [DigitW-1:0] b,
                                                     input logic              cin,
                                                     input logic              sub);
      logic [DigitW:0] t;
      logic [DigitW:0] t_adj;
      logic [DigitW:0] res;
      if (!sub) begin
         t     = {1'b0, a} + {1'b0, b} + {{DigitW{1'b0}}, cin};
         t_adj = t - (DigitW + 1)'(10);
         if (t > (DigitW + 1)'(9)) res = {1'b1, t_adj[DigitW-1:0]};
         else                      res = {1'b0, t[DigitW-1:0]};
      end else begin
         // A negative raw difference shows up as the extra top bit set.
         t     = {1'b0, a} - {1'b0, b} - {{DigitW{1'b0}}, cin};
         t_adj = t + (DigitW + 1)'(10);
         if (t[DigitW]) res = {1'b1, t_adj[DigitW-1:0]};
         else           res = {1'b0, t[DigitW-1:0]};
      end
      return res;
   endfunction

   // Returns {valid, digit}; the lowest set index wins.
   function automatic logic [DigitW:0] key_encode(input logic [9:0] onehot);
      logic [DigitW:0] res;
      res = '0;
      for (int i = 9; i >= 0; i--) begin
         if (onehot[i]) res = {1'b1, DigitW'(i)};
      end
      return res;
   endfunction

endpackage

// File: rtl/calc_seq_if.sv
// calc_seq_if: keypad/command inputs and display outputs of calc_seq.
//   keys[15:0]           one-hot keypad, [9:0] are digits 0-9
//   clear/plus/minus/equal  level-sampled commands
//   ibuf, cbuf           BCD entry buffer and result magnitude, LS digit in [3:0]
//   neg, ovf, busy       result sign, sticky overflow, arithmetic in progress
// master drives the commands, slave (the calculator) drives the display path.
interface calc_seq_if
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS = 8
) ();

   logic [15:0]              keys;
   logic                     clear;
   logic                     plus;
   logic                     minus;
   logic                     equal;
   logic [DigitW*DIGITS-1:0] ibuf;
   logic [DigitW*DIGITS-1:0] cbuf;
   logic                     neg;
   logic                     ovf;
   logic                     busy;

   modport master (
      output keys, clear, plus, minus, equal,
      input  ibuf, cbuf, neg, ovf, busy
   );

   modport slave (
      input  keys, clear, plus, minus, equal,
      output ibuf, cbuf, neg, ovf, busy
   );

endinterface

// File: rtl/bcd_digit_alu.sv
// bcd_digit_alu: combinational single-digit BCD adder/subtractor.
//   a_i, b_i   BCD digit operands
//   cin_i      incoming carry (add) or borrow (subtract)
//   sub_i      1 selects a_i - b_i - cin_i
//   digit_o    corrected BCD digit
//   cout_o     carry or borrow out
module bcd_digit_alu
   import calc_pkg::*;
(
   input  logic [DigitW-1:0] a_i,
   input  logic [DigitW-1:0] b_i,
   input  logic              cin_i,
   input  logic              sub_i,
   output logic [DigitW-1:0] digit_o,
   output logic              cout_o
);

   assign {cout_o, digit_o} = bcd_digit_add(a_i, b_i, cin_i, sub_i);

endmodule

// File: rtl/calc_seq.sv
// calc_seq: keypad BCD calculator with signed accumulator and digit-serial add/sub.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    calc_seq_if slave: keys and commands in, ibuf/cbuf/neg/ovf/busy out
// One bcd_digit_alu is time-shared: operands shift right one digit per cycle and
// the result shifts in from the top, so after DIGITS cycles it is aligned.
module calc_seq
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS = 8
) (
   input logic       clock,
   input logic       reset,
   calc_seq_if.slave bus
);

   localparam int unsigned W     = DigitW * DIGITS;
   localparam int unsigned CntW  = $clog2(DIGITS + 1);
   localparam int unsigned StepW = $clog2(DIGITS);

   state_t            state_q, state_d;
   op_t               pending_q, pending_d;
   logic [9:0]        keys_q, keys_d;
   logic [W-1:0]      ibuf_q, ibuf_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]      cbuf_q, cbuf_d;
   logic              neg_q, neg_d;
   logic              ovf_q, ovf_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      r_q, r_d;
   logic              carry_q, carry_d;
   logic [StepW-1:0]  step_q, step_d;
   logic              mag_add_q, mag_add_d;
   logic              flip_q, flip_d;

   logic [9:0]        key_rise;
   logic              key_valid;
   logic [DigitW-1:0] key_digit;
   logic              cmd_valid;
   op_t               cmd_op;
   logic              last_step;
   logic [DigitW-1:0] alu_a, alu_b, alu_digit;
   logic              alu_cin, alu_sub, alu_cout;

   logic unused_keys;
   assign unused_keys = ^bus.keys[15:10];

   bcd_digit_alu u_alu (
      .a_i     (alu_a),
      .b_i     (alu_b),
      .cin_i   (alu_cin),
      .sub_i   (alu_sub),
      .digit_o (alu_digit),
      .cout_o  (alu_cout)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      keys_d    = bus.keys[9:0];
      ibuf_d    = ibuf_q;
      cnt_d     = cnt_q;
      cbuf_d    = cbuf_q;
      neg_d     = neg_q;
      ovf_d     = ovf_q;
      a_d       = a_q;
      b_d       = b_q;
      r_d       = r_q;
      carry_d   = carry_q;
      step_d    = step_q;
      mag_add_d = mag_add_q;
      flip_d    = flip_q;

      key_rise               = bus.keys[9:0] & ~keys_q;
      {key_valid, key_digit} = key_encode(key_rise);
      cmd_valid              = 1'b0;
      cmd_op                 = OP_NONE;
      last_step              = (step_q == StepW'(DIGITS - 1));

      alu_a   = a_q[DigitW-1:0];
      alu_b   = b_q[DigitW-1:0];
      alu_cin = carry_q;
      alu_sub = (state_q != S_ADD);

      unique case (state_q)
         S_IDLE: begin
            if (bus.equal) begin
               cmd_valid = 1'b1;
               cmd_op    = OP_NONE;
            end else if (bus.minus) begin
               cmd_valid = 1'b1;
               cmd_op    = OP_SUB;
            end else if (bus.plus) begin
               cmd_valid = 1'b1;
               cmd_op    = OP_ADD;
            end
            if (cmd_valid) begin
               // Any command drops a key arriving in the same cycle.
               ibuf_d    = '0;
               cnt_d     = '0;
               pending_d = cmd_op;
               if (pending_q == OP_NONE) begin
                  cbuf_d = ibuf_q;
                  neg_d  = 1'b0;
               end else begin
                  // Same sign and add, or negative and subtract: magnitudes add.
                  mag_add_d = (pending_q == OP_ADD) ^ neg_q;
                  state_d   = mag_add_d ? S_ADD : S_SUB;
                  a_d       = cbuf_q;
                  b_d       = ibuf_q;
                  r_d       = '0;
                  carry_d   = 1'b0;
                  step_d    = '0;
                  flip_d    = 1'b0;
               end
            end else if (key_valid && (cnt_q < CntW'(DIGITS))) begin
               ibuf_d = {ibuf_q[W-DigitW-1:0], key_digit};
               cnt_d  = cnt_q + CntW'(1);
            end
         end
         S_ADD, S_SUB, S_CPL: begin
            a_d     = a_q >> DigitW;
            b_d     = b_q >> DigitW;
            r_d     = {alu_digit, r_q[W-1:DigitW]};
            carry_d = alu_cout;
            step_d  = step_q + StepW'(1);
            if (last_step) begin
               step_d  = '0;
               state_d = S_DONE;
               if ((state_q == S_SUB) && alu_cout) begin
                  // |acc| < B: result is 10^DIGITS - r, recovered as 0 - r.
                  state_d = S_CPL;
                  a_d     = '0;
                  b_d     = r_d;
                  carry_d = 1'b0;
                  flip_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cbuf_d  = r_q;
            ovf_d   = ovf_q | (mag_add_q & carry_q);
            neg_d   = (r_q == '0) ? 1'b0 : (neg_q ^ flip_q);
         end
         default: state_d = S_IDLE;
      endcase

      if (bus.clear) begin
         state_d   = S_IDLE;
         pending_d = OP_NONE;
         ibuf_d    = '0;
         cnt_d     = '0;
         cbuf_d    = '0;
         neg_d     = 1'b0;
         ovf_d     = 1'b0;
         a_d       = '0;
         b_d       = '0;
         r_d       = '0;
         carry_d   = 1'b0;
         step_d    = '0;
         mag_add_d = 1'b0;
         flip_d    = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pending_q <= OP_NONE;
         keys_q    <= '0;
         ibuf_q    <= '0;
         cnt_q     <= '0;
         cbuf_q    <= '0;
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         r_q       <= '0;
         carry_q   <= 1'b0;
         step_q    <= '0;
         mag_add_q <= 1'b0;
         flip_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         keys_q    <= keys_d;
         ibuf_q    <= ibuf_d;
         cnt_q     <= cnt_d;
         cbuf_q    <= cbuf_d;
         neg_q     <= neg_d;
         ovf_q     <= ovf_d;
         a_q       <= a_d;
         b_q       <= b_d;
         r_q       <= r_d;
         carry_q   <= carry_d;
         step_q    <= step_d;
         mag_add_q <= mag_add_d;
         flip_q    <= flip_d;
      end
   end

   assign bus.ibuf = ibuf_q;
   assign bus.cbuf = cbuf_q;
   assign bus.neg  = neg_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: self-checking bench for calc_seq with DIGITS = 8.
// Keypad sequences are written as strings ("123+45=") and expanded into key
// presses and one-cycle command pulses; outputs are sampled on falling edges.
module tb_calc_seq;

   localparam int unsigned DIGITS    = 8;
   localparam int          BusyBound = 100;
   localparam longint      Mod       = 100000000;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   calc_seq_if #(.DIGITS(DIGITS)) bus ();

   calc_seq #(.DIGITS(DIGITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       seq;
      logic [31:0] cbuf;
      logic        neg;
      logic        ovf;
      int          busy;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string s, input logic [31:0] cb, input logic n, input logic o,
                          input int b);
      vec_t v;
      v.seq  = s;
      v.cbuf = cb;
      v.neg  = n;
      v.ovf  = o;
      v.busy = b;
      vecs.push_back(v);
   endtask

   function automatic logic [31:0] to_bcd(input longint v);
      logic [31:0] r;
      longint      t;
      t = v;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

   // Counts falling edges with busy high; gives up after BusyBound.
   task automatic wait_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < BusyBound) begin
         n++;
         @(negedge clock);
      end
      if (n >= BusyBound) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy still high after %0d cycles, required low", n);
      end
   endtask

   task automatic press_key(input int d);
      @(negedge clock);
      bus.keys = 16'(1) << d;
      @(negedge clock);
      bus.keys = '0;
   endtask

   task automatic pulse_cmd(input byte c, output int n);
      @(negedge clock);
      case (c)
         "+":     bus.plus  = 1'b1;
         "-":     bus.minus = 1'b1;
         "=":     bus.equal = 1'b1;
         default: ;
      endcase
      @(negedge clock);
      bus.plus  = 1'b0;
      bus.minus = 1'b0;
      bus.equal = 1'b0;
      wait_idle(n);
   endtask

   task automatic do_clear();
      @(negedge clock);
      bus.clear = 1'b1;
      @(negedge clock);
      bus.clear = 1'b0;
   endtask

   task automatic run_seq(input string s, output int last_busy);
      last_busy = 0;
      for (int i = 0; i < s.len(); i++) begin
         byte c;
         c = s[i];
         if (c >= "0" && c <= "9") press_key(int'(c - "0"));
         else                      pulse_cmd(c, last_busy);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal;
   end

   initial begin
      int nb;
      bus.keys  = '0;
      bus.clear = 1'b0;
      bus.plus  = 1'b0;
      bus.minus = 1'b0;
      bus.equal = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset ibuf", 64'(bus.ibuf), 64'h0);
      check("reset cbuf", 64'(bus.cbuf), 64'h0);
      check("reset neg",  64'(bus.neg),  64'h0);
      check("reset ovf",  64'(bus.ovf),  64'h0);
      check("reset busy", 64'(bus.busy), 64'h0);

      // Directed vectors: sequence, cbuf, neg, ovf, busy cycles of the last command.
      add_vec("123+45=",     32'h00000168, 1'b0, 1'b0, 9);
      add_vec("5-12=",       32'h00000007, 1'b1, 1'b0, 17);
      add_vec("99999999+1=", 32'h00000000, 1'b0, 1'b1, 9);
      add_vec("10+5-3=",     32'h00000012, 1'b0, 1'b0, 9);
      add_vec("0-7+4=",      32'h00000003, 1'b1, 1'b0, 9);
      add_vec("0-7-5=",      32'h00000012, 1'b1, 1'b0, 9);
      add_vec("0-7+7=",      32'h00000000, 1'b0, 1'b0, 9);
      add_vec("3-8+9=",      32'h00000004, 1'b0, 1'b0, 17);
      add_vec("42=",         32'h00000042, 1'b0, 1'b0, 0);
      add_vec("999+1=",      32'h00001000, 1'b0, 1'b0, 9);

      // Random two-operand vectors from an integer model.
      for (int i = 0; i < 6; i++) begin
         longint a, b, res, mag;
         logic   n, o;
         int     op, bz;
         a   = longint'($urandom_range(0, 99999999));
         b   = (i % 2 == 1) ? longint'($urandom_range(0, 999))
                            : longint'($urandom_range(0, 99999999));
         op  = int'($urandom_range(0, 1));
         res = (op == 1) ? a - b : a + b;
         n   = (res < 0);
         mag = n ? -res : res;
         o   = (mag >= Mod);
         mag = mag % Mod;
         if (mag == 0) n = 1'b0;
         bz  = (op == 1 && a < b) ? 17 : 9;
         add_vec($sformatf("%0d%s%0d=", a, (op == 1) ? "-" : "+", b), to_bcd(mag), n, o, bz);
      end

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t e;
         do_clear();
         sb.push_back(vecs[i]);
         run_seq(vecs[i].seq, nb);
         e = sb.pop_front();
         check({e.seq, " cbuf"}, 64'(bus.cbuf), 64'(e.cbuf));
         check({e.seq, " neg"},  64'(bus.neg),  64'(e.neg));
         check({e.seq, " ovf"},  64'(bus.ovf),  64'(e.ovf));
         check({e.seq, " busy"}, 64'(nb),       64'(e.busy));
         check({e.seq, " ibuf"}, 64'(bus.ibuf), 64'h0);
      end

      // Entry buffer holds DIGITS digits; the ninth is dropped.
      do_clear();
      for (int d = 1; d <= 9; d++) press_key(d);
      check("nine digits ibuf", 64'(bus.ibuf), 64'h12345678);

      // Several digit keys at once: lowest index wins. Keys 15:10 do nothing.
      do_clear();
      @(negedge clock);
      bus.keys = 16'h0028;
      @(negedge clock);
      bus.keys = '0;
      check("multi key ibuf", 64'(bus.ibuf), 64'h3);
      @(negedge clock);
      bus.keys = 16'h0400;
      @(negedge clock);
      bus.keys = '0;
      check("ignored key ibuf", 64'(bus.ibuf), 64'h3);

      // Key in the same cycle as a load command is dropped.
      do_clear();
      press_key(2);
      @(negedge clock);
      bus.keys = 16'h0040;
      bus.plus = 1'b1;
      @(negedge clock);
      bus.keys = '0;
      bus.plus = 1'b0;
      check("key+cmd ibuf", 64'(bus.ibuf), 64'h0);
      check("key+cmd cbuf", 64'(bus.cbuf), 64'h2);

      // Overflow is sticky across later entry and loads until clear.
      do_clear();
      run_seq("99999999+1=", nb);
      press_key(5);
      check("ovf after key", 64'(bus.ovf),  64'h1);
      check("ovf entry ibuf", 64'(bus.ibuf), 64'h5);
      run_seq("=", nb);
      check("ovf load cbuf", 64'(bus.cbuf), 64'h5);
      check("ovf after load", 64'(bus.ovf), 64'h1);
      do_clear();
      check("ovf after clear", 64'(bus.ovf), 64'h0);

      // Key and a second equal during busy are ignored.
      do_clear();
      run_seq("5-12", nb);
      @(negedge clock);
      bus.equal = 1'b1;
      @(negedge clock);
      bus.equal = 1'b0;
      @(negedge clock);
      bus.keys = 16'h0080;
      @(negedge clock);
      bus.keys  = '0;
      bus.equal = 1'b1;
      @(negedge clock);
      bus.equal = 1'b0;
      wait_idle(nb);
      repeat (3) @(negedge clock);
      check("busy ignore ibuf", 64'(bus.ibuf), 64'h0);
      check("busy ignore cbuf", 64'(bus.cbuf), 64'h7);
      check("busy ignore neg",  64'(bus.neg),  64'h1);

      // Clear during the complement pass.
      do_clear();
      run_seq("5-12", nb);
      @(negedge clock);
      bus.equal = 1'b1;
      @(negedge clock);
      bus.equal = 1'b0;
      repeat (11) @(negedge clock);
      check("cpl busy before clear", 64'(bus.busy), 64'h1);
      bus.clear = 1'b1;
      @(negedge clock);
      bus.clear = 1'b0;
      check("cpl clear cbuf", 64'(bus.cbuf), 64'h0);
      check("cpl clear neg",  64'(bus.neg),  64'h0);
      check("cpl clear busy", 64'(bus.busy), 64'h0);

      // Asynchronous reset in the middle of an add.
      do_clear();
      run_seq("123+45", nb);
      @(negedge clock);
      bus.equal = 1'b1;
      @(negedge clock);
      bus.equal = 1'b0;
      repeat (3) @(negedge clock);
      check("add busy before reset", 64'(bus.busy), 64'h1);
      #2 reset = 1'b1;
      #1;
      check("async reset cbuf", 64'(bus.cbuf), 64'h0);
      check("async reset busy", 64'(bus.busy), 64'h0);
      check("async reset ibuf", 64'(bus.ibuf), 64'h0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
